// File: rtl/mac_sequencer16.sv
// Job sequencer for one float16 MAC PE: clear, stream LEN operand pairs, drain, hand off result.
// Optional MAC_ZERO_SKIP_EN: suppress pe_en for +/-0 operands and count them on skip_cnt.
module mac_sequencer16 #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  pe_clr,
  output logic                  pe_en,
  output logic [DATA_WIDTH-1:0] pe_a,
  output logic [DATA_WIDTH-1:0] pe_b,
  input  logic [DATA_WIDTH-1:0] pe_result,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data
`ifdef MAC_ZERO_SKIP_EN
  ,
  output logic [LEN_WIDTH-1:0]  skip_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

  state_t               state, state_nxt;
  logic [LEN_WIDTH-1:0] remaining;
  logic                 drain_cnt;
  logic                 accept;
  logic                 fire;

  assign accept = in_valid & in_ready;

`ifdef MAC_ZERO_SKIP_EN
  logic zero_op;
  // Exponent+mantissa zero on either side means the product is +/-0.
  assign zero_op = ~|in_a[DATA_WIDTH-2:0] | ~|in_b[DATA_WIDTH-2:0];
  assign fire    = accept & ~zero_op;
`else
  assign fire    = accept;
`endif

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    in_ready  = 1'b0;
    pe_clr    = 1'b0;
    res_valid = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = CLEAR;
      end
      CLEAR: begin
        pe_clr    = 1'b1;
        state_nxt = (remaining != '0) ? RUN : DRAIN;
      end
      RUN: begin
        in_ready = 1'b1;
        if (accept && remaining == LEN_WIDTH'(1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt) state_nxt = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      remaining <= '0;
      drain_cnt <= 1'b0;
      pe_en     <= 1'b0;
      pe_a      <= '0;
      pe_b      <= '0;
      res_data  <= '0;
    end else begin
      state     <= state_nxt;
      pe_en     <= fire;
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      if (state == IDLE && start)
        remaining <= len;
      else if (accept && remaining != '0)
        remaining <= remaining - LEN_WIDTH'(1);
      if (fire) begin
        pe_a <= in_a;
        pe_b <= in_b;
      end
      // Second drain cycle: the final pe_en pulse has landed in the PE.
      if (state == DRAIN && drain_cnt)
        res_data <= pe_result;
    end
  end

`ifdef MAC_ZERO_SKIP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      skip_cnt <= '0;
    else if (state == CLEAR)
      skip_cnt <= '0;
    else if (accept && zero_op)
      skip_cnt <= skip_cnt + LEN_WIDTH'(1);
  end
`endif

endmodule

// File: tb/tb_mac_sequencer16.sv
// Randomized scoreboard bench for mac_sequencer16 with an integer-valued float16 PE model.
module tb_mac_sequencer16;
  localparam int DW = 16;
  localparam int LW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic          busy, in_ready, pe_clr, pe_en, res_valid;
  logic          in_valid = 1'b0;
  logic          res_ready = 1'b0;
  logic [DW-1:0] in_a = '0, in_b = '0;
  logic [DW-1:0] pe_a, pe_b, pe_result, res_data;
`ifdef MAC_ZERO_SKIP_EN
  logic [LW-1:0] skip_cnt;
`endif

  mac_sequencer16 #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .pe_clr(pe_clr), .pe_en(pe_en), .pe_a(pe_a), .pe_b(pe_b),
    .pe_result(pe_result), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data)
`ifdef MAC_ZERO_SKIP_EN
    , .skip_cnt(skip_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    int          n;
    int          pulses;
    int          skips;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] pa[$], pb[$];
  int          checks = 0, failures = 0;
  int          cyc = 0;
  bit          stall_req = 0;

  function automatic logic [15:0] int2h(int v);
    logic [15:0] r;
    int m, e;
    r = '0;
    m = (v < 0) ? -v : v;
    if (m == 0) return 16'h0000;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    r[15]    = (v < 0);
    r[14:10] = 5'(e + 15);
    r[9:0]   = 10'(m << (10 - e));
    return r;
  endfunction

  function automatic int h2int(logic [15:0] h);
    int e, m;
    if (h[14:0] == '0) return 0;
    e = int'(h[14:10]) - 15;
    m = int'({1'b1, h[9:0]}) >> (10 - e);
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] rand_op();
    int r;
    r = $urandom_range(0, 9);
    if (r == 9) return 16'h8000;
    return int2h(r - 4);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // PE stand-in: operands are small integers, so the dot product is exact.
  int acc;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      acc <= 0;
    else if (pe_clr) acc <= 0;
    else if (pe_en)  acc <= acc + h2int(pe_a) * h2int(pe_b);
  end
  always_comb pe_result = int2h(acc);

  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(posedge clk);
    #1;
    if (stall_req && res_valid) begin
      res_ready = 1'b0;
      repeat (10) begin @(posedge clk); #1; end
      stall_req = 0;
    end
    res_ready = ($urandom_range(0, 2) != 0);
  end

  int          accepts = 0, pulses = 0, last_acc_edge = 0;
  logic        prev_rv = 1'b0, prev_rr = 1'b0;
  logic [15:0] held = '0;
  always @(negedge clk) begin
    if (!reset) begin
      accepts = 0; pulses = 0; prev_rv = 1'b0; prev_rr = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        accepts++;
        last_acc_edge = cyc + 1;
      end
      if (pe_en) pulses++;
      if (res_valid && prev_rv && !prev_rr) chk("res_hold", res_data, held);
      if (res_valid && !prev_rv && sbq.size() > 0 && sbq[0].n > 0)
        chk("latency", cyc, last_acc_edge + 2);
      if (res_valid && res_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("res_data", res_data, e.data);
          chk("accepts", accepts, e.n);
          chk("pe_en_pulses", pulses, e.pulses);
`ifdef MAC_ZERO_SKIP_EN
          chk("skip_cnt", skip_cnt, e.skips);
`endif
        end
        accepts = 0;
        pulses  = 0;
      end
      prev_rv = res_valid;
      prev_rr = res_ready;
      held    = res_data;
    end
  end

  task automatic run_job(input int n, input bit gappy, input int abort_at);
    exp_t e;
    int   sum, i, guard;
    bit   accepted;
    guard = 0;
    while (busy && guard < 200) begin @(posedge clk); #1; guard++; end
    if (busy) begin
      chk("idle_wait", 1, 0);
      return;
    end
    sum = 0; e.skips = 0;
    for (int k = 0; k < n; k++) begin
      sum += h2int(pa[k]) * h2int(pb[k]);
      if (pa[k][14:0] == '0 || pb[k][14:0] == '0) e.skips++;
    end
    e.n = n;
    e.data = int2h(sum);
`ifdef MAC_ZERO_SKIP_EN
    e.pulses = n - e.skips;
`else
    e.pulses = n;
`endif
    if (abort_at < 0) sbq.push_back(e);
    start = 1'b1; len = LW'(n);
    @(posedge clk); #1;
    start = 1'b0; len = LW'($urandom);
    i = 0; guard = 0;
    while (i < n && guard < 1000) begin
      if (abort_at == i) begin
        reset = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_pe_en", pe_en, 0);
        chk("abort_res_valid", res_valid, 0);
        in_valid = 1'b0;
        @(negedge clk); #2;
        reset = 1'b1;
        return;
      end
      in_a = pa[i]; in_b = pb[i];
      in_valid = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
      start = ($urandom_range(0, 5) == 0);
      len = LW'($urandom);
      accepted = in_valid && in_ready;
      @(posedge clk); #1;
      if (accepted) i++;
      guard++;
    end
    if (i < n) chk("feed_timeout", i, n);
    start = 1'b0;
    in_valid = 1'($urandom_range(0, 1));
    in_a = $urandom; in_b = $urandom;
  endtask

  task automatic fill_rand(input int n);
    pa.delete(); pb.delete();
    for (int k = 0; k < n; k++) begin
      pa.push_back(rand_op());
      pb.push_back(rand_op());
    end
  endtask

  initial begin
    int guard;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl", {busy, in_ready, pe_clr, pe_en, res_valid}, 5'b0);
    chk("reset_data", {pe_a, pe_b, res_data}, 48'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    fill_rand(8);
    run_job(8, 1'b0, 3);

    pa = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00};
    pb = '{16'h4000, 16'h4000, 16'h4000, 16'h4000};
    run_job(4, 1'b0, -1);

    fill_rand(3);
    run_job(3, 1'b1, -1);

    run_job(0, 1'b0, -1);

    stall_req = 1;
    fill_rand(5);
    run_job(5, 1'b0, -1);

    pa = '{16'h0000, 16'h4000, 16'h8000, 16'h3C00};
    pb = '{16'h4200, 16'h4200, 16'h3C00, 16'h3C00};
    run_job(4, 1'b0, -1);

    for (int j = 0; j < 25; j++) begin
      int n;
      n = $urandom_range(0, 12);
      fill_rand(n);
      run_job(n, 1'($urandom_range(0, 1)), -1);
    end

    guard = 0;
    while (sbq.size() != 0 && guard < 300) begin @(posedge clk); #1; guard++; end
    chk("scoreboard_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
